// File: rtl/mptw_mem_arbiter.sv
// Round-robin arbiter sharing one MEM port to the D$ among the MPT walkers (load, store, IFU, PTW).
// Optional response watchdog with DRAIN state is enabled by defining MPTW_ARB_TIMEOUT_EN.
module mptw_mem_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              flush_i,
  input  logic [NUM_REQ-1:0]                s_mem_req,
  output logic [NUM_REQ-1:0]                s_mem_gnt,
  output logic [NUM_REQ-1:0]                s_mem_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     s_mem_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     s_mem_wdata,
  input  logic [NUM_REQ-1:0]                s_mem_we,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   s_mem_be,
  output logic [DATA_WIDTH-1:0]             s_mem_rdata,
  output logic [NUM_REQ-1:0]                s_mem_error,
  output logic                              m_mem_req,
  input  logic                              m_mem_gnt,
  input  logic                              m_mem_valid,
  output logic [ADDR_WIDTH-1:0]             m_mem_addr,
  output logic [DATA_WIDTH-1:0]             m_mem_wdata,
  output logic                              m_mem_we,
  output logic [DATA_WIDTH/8-1:0]           m_mem_be,
  input  logic [DATA_WIDTH-1:0]             m_mem_rdata,
  input  logic                              m_mem_error,
  output logic                              busy_o,
  output logic [$clog2(NUM_REQ)-1:0]        owner_o
);

  localparam int unsigned IW  = $clog2(NUM_REQ);
  localparam int unsigned BEW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StRsp
`ifdef MPTW_ARB_TIMEOUT_EN
    ,
    StDrain
`endif
  } state_e;

  state_e          state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   rr_ptr;
  logic            drop;
  logic            busy;
  logic [IW-1:0]   owner_next;
  logic            found;
  logic [IW-1:0]   winner;
  int unsigned     cand;
  logic            rsp_ok;
  logic            owner_req;

`ifdef MPTW_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer;
  logic          timer_last;
  assign timer_last = (timer == TW'(TIMEOUT_CYCLES - 1));
`endif

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
  logic [BEW-1:0]        be_arr    [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = s_mem_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = s_mem_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    assign be_arr[g]    = s_mem_be[g*BEW +: BEW];
  end

  // Explicit wrap so a non-power-of-two NUM_REQ still cycles correctly.
  assign owner_next = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
  assign owner_req  = s_mem_req[owner];

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(rr_ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && s_mem_req[IW'(cand)]) begin
        found  = 1'b1;
        winner = IW'(cand);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= StIdle;
      owner  <= '0;
      rr_ptr <= '0;
      drop   <= 1'b0;
      busy   <= 1'b0;
`ifdef MPTW_ARB_TIMEOUT_EN
      timer  <= '0;
`endif
    end else begin
      case (state)
        StIdle: begin
          if (found && !flush_i) begin
            owner <= winner;
            state <= StReq;
            busy  <= 1'b1;
          end
        end
        StReq: begin
          if (owner_req && m_mem_gnt) begin
            state <= StRsp;
            drop  <= flush_i;
`ifdef MPTW_ARB_TIMEOUT_EN
            timer <= '0;
`endif
          end else if (!owner_req) begin
            // Requester withdrew before being granted.
            state  <= StIdle;
            rr_ptr <= owner_next;
            busy   <= 1'b0;
          end
        end
        StRsp: begin
          if (flush_i) drop <= 1'b1;
          if (m_mem_valid) begin
            state  <= StIdle;
            rr_ptr <= owner_next;
            drop   <= 1'b0;
            busy   <= 1'b0;
          end
`ifdef MPTW_ARB_TIMEOUT_EN
          else if (timer_last) begin
            state <= StDrain;
          end else begin
            timer <= timer + TW'(1);
          end
`endif
        end
`ifdef MPTW_ARB_TIMEOUT_EN
        StDrain: begin
          // Swallow the late response before releasing the port.
          if (m_mem_valid) begin
            state  <= StIdle;
            rr_ptr <= owner_next;
            drop   <= 1'b0;
            busy   <= 1'b0;
          end
        end
`endif
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    m_mem_req   = 1'b0;
    m_mem_addr  = '0;
    m_mem_wdata = '0;
    m_mem_we    = 1'b0;
    m_mem_be    = '0;
    s_mem_gnt   = '0;
    s_mem_valid = '0;
    s_mem_error = '0;
    s_mem_rdata = '0;
    rsp_ok      = 1'b0;
    case (state)
      StReq: begin
        m_mem_req        = owner_req;
        m_mem_addr       = addr_arr[owner];
        m_mem_wdata      = wdata_arr[owner];
        m_mem_we         = s_mem_we[owner];
        m_mem_be         = be_arr[owner];
        s_mem_gnt[owner] = m_mem_gnt & owner_req;
      end
      StRsp: begin
        s_mem_rdata        = m_mem_rdata;
        rsp_ok             = ~drop & ~flush_i;
        s_mem_valid[owner] = m_mem_valid & rsp_ok;
        s_mem_error[owner] = m_mem_valid & m_mem_error & rsp_ok;
`ifdef MPTW_ARB_TIMEOUT_EN
        if (!m_mem_valid && timer_last) begin
          s_mem_valid[owner] = rsp_ok;
          s_mem_error[owner] = rsp_ok;
        end
`endif
      end
      default: ;
    endcase
  end

  assign busy_o  = busy;
  assign owner_o = owner;

endmodule
